gpio_intr_ctrl: RTL
===================

// Module: gpio_intr_ctrl
// PURPOSE
//  Input-side companion to the GPIO output/enable stage. Synchronises raw pad inputs
//  and (optionally) glitch-filters them. Registers the clean value as data_in_o for the
//  DATA_IN register. Detects per-bit rising/falling edges and high/low levels and
//  accumulates them in a W1C interrupt-state register, with per-bit masked interrupts.
// PARAMETERS
//  WIDTH          32  number of GPIO bits
//  SYNC_STAGES    2   flops in the input synchroniser (>=2)
//  FILTER_CYCLES  16  stable cycles required before a filtered bit changes (>=2)
// PORTS
//  clk_i               in   1      clock
//  rst_ni              in   1      async reset, active-low
//  cio_gpio_i          in   WIDTH  raw asynchronous pad inputs
//  intr_en_rising_i    in   WIDTH  per-bit rising-edge interrupt enable
//  intr_en_falling_i   in   WIDTH  per-bit falling-edge interrupt enable
//  intr_en_lvlhigh_i   in   WIDTH  per-bit level-high interrupt enable
//  intr_en_lvllow_i    in   WIDTH  per-bit level-low interrupt enable
//  intr_enable_i       in   WIDTH  per-bit mask from intr_state to intr_gpio_o
//  intr_state_clr_i    in   WIDTH  W1C data for intr_state
//  intr_state_clr_qe_i in   1      one-cycle strobe qualifying intr_state_clr_i
//  intr_test_i         in   WIDTH  bits to force-set in intr_state
//  intr_test_qe_i      in   1      one-cycle strobe qualifying intr_test_i
//  filter_en_i         in   WIDTH  per-bit filter enable (ignored without macro)
//  data_in_o           out  WIDTH  synchronised/filtered input value
//  intr_state_o        out  WIDTH  interrupt state register
//  intr_gpio_o         out  WIDTH  intr_state_o & intr_enable_i, combinational
// BEHAVIOUR
//  - Reset (async, rst_ni=0): sync chain, filter state, data_in_o, prev_q and intr_state_o
//    all go to 0. intr_gpio_o therefore reads 0. Reset mid-filter discards the count.
//  - Sync: cio_gpio_i passes through a SYNC_STAGES flop chain -> sync_q.
//    data_in_o = sync_q (filter off), registered.
//  - Latency, filter off: pad change settled before edge N gives data_in_o at edge
//    N+SYNC_STAGES-1 and intr_state_o at edge N+SYNC_STAGES.
//  - prev_q <= data_in_o every cycle. Events are combinational:
//    rise = data_in_o & ~prev_q
//    fall = ~data_in_o & prev_q
//    hi = data_in_o
//    lo = ~data_in_o
//    evt = (rise&en_rising) | (fall&en_falling) | (hi&en_lvlhigh) | (lo&en_lvllow)
//  - intr_state next = (state & ~(clr_qe ? clr : 0)) | evt | (test_qe ? test : 0).
//    Set wins over clear in the same cycle, for both events and test.
//  - Level interrupts re-assert every cycle while the level holds. A W1C only clears
//    them once the level or enable drops.
//  - Edges are single-cycle events. A cleared edge bit stays 0 until the next edge.
//  - A bit high at reset release produces a rising event, since prev_q resets to 0.
//    This is intended; software enables interrupts after reset.
//  - Enable changes take effect on the same cycle's evt. Disabling does not clear state.
//  - intr_gpio_o is purely combinational from intr_state_o and intr_enable_i.
// CONFIGURATION
//  GPIO_INPUT_FILTER_EN defined:
//    - Each bit has a counter of $clog2(FILTER_CYCLES) bits and a filt_q bit.
//    - With filter_en_i[b]=1: while sync_q[b]!=filt_q[b] the counter increments. Any
//      cycle with sync_q[b]==filt_q[b] resets it to 0.
//    - When the counter reaches FILTER_CYCLES-1 and the bit still differs, filt_q[b]
//      toggles and the counter resets. data_in_o[b]=filt_q[b].
//    - Adds FILTER_CYCLES cycles of latency. Pulses shorter than FILTER_CYCLES are dropped.
//    - With filter_en_i[b]=0: filt_q[b] tracks sync_q[b] each cycle, counter held at 0.
//  GPIO_INPUT_FILTER_EN undefined: no filter logic, filter_en_i unused,
//    data_in_o = sync_q.
// TESTING
//  1. Reset, pads=0, all enables 0; toggle pad[3] 0->1
//     -> data_in_o[3]=1 after 2 clks; intr_state_o stays 0.
//  2. en_rising=0x1; pad[0] 0->1 -> intr_state_o=0x1 at clk 3.
//     clr=0x1 with qe -> 0 next clk; stays 0 while pad high.
//  3. en_lvlhigh=0x80000000, pad[31]=1; W1C bit31 -> still 1 next cycle.
//     Pad to 0, then W1C -> 0.
//  4. intr_test=0xA5A5A5A5 with qe, intr_enable=0x0000FFFF
//     -> intr_state_o=0xA5A5A5A5, intr_gpio_o=0x0000A5A5.
//     Clear and test the same bit in one cycle -> bit stays 1.
//  5. GPIO_INPUT_FILTER_EN, filter_en=0x1:
//     - 10-cycle pulse on pad[0] -> data_in_o[0] stays 0, no rising event.
//     - 20-cycle high -> data_in_o[0]=1 after 2+16 clks.
//  6. Assert rst_ni low mid-filter-count and with intr_state=0xFFFFFFFF
//     -> all outputs 0 immediately; no event on release with pads=0.

Source files
------------

// File: rtl/gpio_intr_ctrl.sv
// GPIO input stage: synchroniser, optional glitch filter, edge/level interrupts.
// Optional filter enabled by defining GPIO_INPUT_FILTER_EN.
module gpio_intr_ctrl #(
    parameter int WIDTH         = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] cio_gpio_i,
    input  logic [WIDTH-1:0] intr_en_rising_i,
    input  logic [WIDTH-1:0] intr_en_falling_i,
    input  logic [WIDTH-1:0] intr_en_lvlhigh_i,
    input  logic [WIDTH-1:0] intr_en_lvllow_i,
    input  logic [WIDTH-1:0] intr_enable_i,
    input  logic [WIDTH-1:0] intr_state_clr_i,
    input  logic             intr_state_clr_qe_i,
    input  logic [WIDTH-1:0] intr_test_i,
    input  logic             intr_test_qe_i,
    input  logic [WIDTH-1:0] filter_en_i,
    output logic [WIDTH-1:0] data_in_o,
    output logic [WIDTH-1:0] intr_state_o,
    output logic [WIDTH-1:0] intr_gpio_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] data_s;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr_m;
    logic [WIDTH-1:0] test_m;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= cio_gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_INPUT_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // A bit only flips after it has differed for FILTER_CYCLES straight cycles
    always_comb begin
        filt_d = filt_q;
        for (int b = 0; b < WIDTH; b++) begin
            cnt_d[b] = cnt_q[b];
            if (!filter_en_i[b]) begin
                filt_d[b] = sync_s[b];
                cnt_d[b]  = '0;
            end else if (sync_s[b] == filt_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_MAX) begin
                filt_d[b] = ~filt_q[b];
                cnt_d[b]  = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q <= '0;
            for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int b = 0; b < WIDTH; b++) cnt_q[b] <= cnt_d[b];
        end
    end

    assign data_s = filt_q;
`else
    logic unused_filter_en;
    assign unused_filter_en = ^filter_en_i;
    assign data_s = sync_s;
`endif

    assign evt = (data_s & ~prev_q & intr_en_rising_i)
               | (~data_s & prev_q & intr_en_falling_i)
               | (data_s & intr_en_lvlhigh_i)
               | (~data_s & intr_en_lvllow_i);

    assign clr_m  = intr_state_clr_qe_i ? intr_state_clr_i : '0;
    assign test_m = intr_test_qe_i ? intr_test_i : '0;

    // Sets are OR-ed after the clear so they win in the same cycle
    assign state_d = (state_q & ~clr_m) | evt | test_m;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= '0;
            state_q <= '0;
        end else begin
            prev_q  <= data_s;
            state_q <= state_d;
        end
    end

    assign data_in_o    = data_s;
    assign intr_state_o = state_q;
    assign intr_gpio_o  = state_q & intr_enable_i;

endmodule
